alu_result_drain: RTL and testbench
===================================

Name: alu_result_drain

Overview:
- Sequential consumer of the 64-bit ALU result bus C.
- Captures C together with its 5-bit opcode, then drains it onto the 32-bit internal datapath bus in one or two handshaked beats, tagging each beat with its destination: general register (Z low), LO or HI.
- Sits between the ALU output and the register-file/HI-LO writeback path.
- Lets the control unit issue the next ALU operation while the previous result is still being written.

Parameters:
- DATA_W, 32, width of one bus beat; the capture width is 2*DATA_W.

Ports:
- clk  input  1  single system clock; all logic on rising edge
- clr  input  1  synchronous, active-low reset
- alu_c  input  2*DATA_W  ALU result C
- alu_op  input  5  opcode that produced alu_c
- cap  input  1  capture request; accepted when cap && cap_ready
- cap_ready  output  1  high only in IDLE
- bus_out  output  DATA_W  beat data
- bus_sel  output  2  destination of the beat: 00 general/Z low, 01 LO, 10 HI; 11 never driven
- bus_valid  output  1  beat valid
- bus_ready  input  1  sink accepts the beat when bus_valid && bus_ready
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the final beat is accepted
- op_err  output  1  one-cycle pulse when an unsupported opcode is captured
- zero  output  1  zero flag of the captured result (see Optional Feature)

Behaviour:
- Reset (clr=0 at a rising edge):
  - State goes to IDLE; held registers clear to 0.
  - Outputs: bus_out=0, bus_sel=00, bus_valid=0, busy=0, done=0, op_err=0, zero=0, cap_ready=1.
  - Reset takes priority over every other event, including mid-drain; a partially drained result is discarded and no done pulse is produced.
- States: IDLE, BEAT1, BEAT2, FIN.
- IDLE:
  - cap_ready=1.
  - On cap, register alu_c and alu_op, then classify the opcode.
    - Multiply (10000): go to BEAT1 with LO=C[31:0], then HI=C[63:32].
    - Divide (01111): go to BEAT1 with LO=C[63:32] (quotient), then HI=C[31:0] (remainder).
    - Opcodes 00000–01110, 10001, 10010, 10011: single beat. Go to BEAT1 with bus_sel=00 and data C[31:0]; C[63:32] is ignored.
    - Opcodes 10100–11111: pulse op_err next cycle, emit no beat, stay in IDLE.
- BEAT1:
  - bus_valid=1.
  - On accept: two-beat ops go to BEAT2; single-beat ops go to FIN.
- BEAT2:
  - bus_valid=1, carrying the HI beat.
  - On accept, go to FIN.
- FIN:
  - done=1 for exactly one cycle, then go to IDLE.
  - cap is not accepted in FIN.
- Latency:
  - cap accepted at edge N gives bus_valid=1 from the cycle following edge N.
  - With bus_ready held at 1: single-beat op has done high in cycle N+2; two-beat op in cycle N+3.
  - Minimum spacing between accepted captures is 3 cycles (single-beat) or 4 cycles (two-beat).
- Handshake rules:
  - While bus_valid && !bus_ready, bus_out and bus_sel hold stable and bus_valid stays high.
  - bus_valid never drops without an accept, except on reset.
  - Unbounded backpressure is legal.
- alu_c and alu_op are sampled only on the capture edge; later changes are ignored.
- cap while busy is ignored. The requester must wait for cap_ready; the block does not buffer.

Optional Feature:
- Macro: ALU_DRAIN_ZERO_FLAG_EN.
- Defined:
  - zero is registered at the capture edge.
  - For multiply/divide: zero = (alu_c == 0) across all 64 bits.
  - For single-beat ops: zero = (alu_c[31:0] == 0).
  - zero holds until the next capture or reset; unsupported opcodes set zero=0.
- Undefined: zero is tied to 0 and no comparator logic is built.

Test Plan:
- Add: op 00011, C=64'h0000_0000_0000_0007, cap, bus_ready=1 -> one beat, bus_sel=00, bus_out=7; done two cycles after cap; zero=0.
- Multiply: op 10000, C=64'h0000_0001_8000_0000 -> beat LO 32'h8000_0000 (sel 01), then HI 32'h0000_0001 (sel 10); done once.
- Divide: op 01111, C={quotient 32'd5, remainder 32'd3} -> LO=5 (sel 01), then HI=3 (sel 10).
- Backpressure on the multiply case:
  - Hold bus_ready=0 for 4 cycles: bus_out and bus_sel stay stable and bus_valid stays 1.
  - Also drive cap with a new C during this window: it is ignored and cap_ready=0.
- Illegal opcode 10110 -> op_err pulses one cycle, no bus_valid, cap_ready stays 1.
- Reset mid-drain: assert clr=0 while in BEAT2 -> next edge all outputs at reset values, no done; a following capture of op 00011 with C=0 drains normally and sets zero=1 (macro on).

Source files
------------

// File: rtl/alu_result_drain_if.sv
// ALU result drain bus: capture side (ALU result, opcode, capture handshake)
// and drain side (beat data, destination tag, beat handshake, status flags).
// The control/ALU side uses the master modport; the drain block uses slave.
interface alu_result_drain_if #(
  parameter int DATA_W = 32
);
  logic [2*DATA_W-1:0] alu_c;
  logic [4:0]          alu_op;
  logic                cap;
  logic                cap_ready;
  logic [DATA_W-1:0]   bus_out;
  logic [1:0]          bus_sel;
  logic                bus_valid;
  logic                bus_ready;
  logic                busy;
  logic                done;
  logic                op_err;
  logic                zero;

  modport master (
    output alu_c, alu_op, cap, bus_ready,
    input  cap_ready, bus_out, bus_sel, bus_valid, busy, done, op_err, zero
  );

  modport slave (
    input  alu_c, alu_op, cap, bus_ready,
    output cap_ready, bus_out, bus_sel, bus_valid, busy, done, op_err, zero
  );
endinterface

// File: rtl/alu_result_drain.sv
// alu_result_drain: captures the 64-bit ALU result C with its opcode and
// drains it onto the 32-bit writeback bus in one beat (general register) or
// two beats (LO then HI for multiply/divide). Unsupported opcodes raise a
// one-cycle op_err and produce no beat.
// Optional feature macro: ALU_DRAIN_ZERO_FLAG_EN (registered zero flag of the
// captured result; when undefined, zero is tied low).
module alu_result_drain #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  alu_result_drain_if.slave bus
);

  localparam logic [4:0] OP_DIV          = 5'b01111;
  localparam logic [4:0] OP_MUL          = 5'b10000;
  localparam logic [4:0] OP_FIRST_ILLEGAL = 5'b10100;

  localparam logic [1:0] SEL_Z  = 2'b00;
  localparam logic [1:0] SEL_LO = 2'b01;
  localparam logic [1:0] SEL_HI = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    BEAT1,
    BEAT2,
    FIN
  } state_t;

  state_t              state_q;
  logic [2*DATA_W-1:0] c_q;
  logic [4:0]          op_q;
  logic [DATA_W-1:0]   bus_out_q;
  logic [1:0]          bus_sel_q;
  logic                bus_valid_q;
  logic                cap_ready_q;
  logic                busy_q;
  logic                done_q;
  logic                op_err_q;

  logic                two_beat;
  logic [DATA_W-1:0]   hi_beat;

  // Second beat comes from the held result: multiply sends C[63:32] as HI,
  // divide sends the remainder C[31:0] as HI.
  assign two_beat = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign hi_beat  = (op_q == OP_MUL) ? c_q[2*DATA_W-1:DATA_W] : c_q[DATA_W-1:0];

  // Drain FSM with all handshake/status outputs registered.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all updates see pre-edge values;
    // a blocking = would let later lines observe this edge's new state.
    if (!clr) begin
      state_q     <= IDLE;
      c_q         <= '0;
      op_q        <= '0;
      bus_out_q   <= '0;
      bus_sel_q   <= SEL_Z;
      bus_valid_q <= 1'b0;
      cap_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      op_err_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      op_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cap) begin
            c_q  <= bus.alu_c;
            op_q <= bus.alu_op;
            if (bus.alu_op >= OP_FIRST_ILLEGAL) begin
              op_err_q <= 1'b1;
            end else begin
              state_q     <= BEAT1;
              bus_valid_q <= 1'b1;
              cap_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              if (bus.alu_op == OP_MUL) begin
                bus_out_q <= bus.alu_c[DATA_W-1:0];
                bus_sel_q <= SEL_LO;
              end else if (bus.alu_op == OP_DIV) begin
                bus_out_q <= bus.alu_c[2*DATA_W-1:DATA_W];
                bus_sel_q <= SEL_LO;
              end else begin
                bus_out_q <= bus.alu_c[DATA_W-1:0];
                bus_sel_q <= SEL_Z;
              end
            end
          end
        end
        BEAT1: begin
          if (bus.bus_ready) begin
            if (two_beat) begin
              state_q   <= BEAT2;
              bus_out_q <= hi_beat;
              bus_sel_q <= SEL_HI;
            end else begin
              state_q     <= FIN;
              bus_valid_q <= 1'b0;
              bus_out_q   <= '0;
              bus_sel_q   <= SEL_Z;
              done_q      <= 1'b1;
            end
          end
        end
        BEAT2: begin
          if (bus.bus_ready) begin
            state_q     <= FIN;
            bus_valid_q <= 1'b0;
            bus_out_q   <= '0;
            bus_sel_q   <= SEL_Z;
            done_q      <= 1'b1;
          end
        end
        FIN: begin
          state_q     <= IDLE;
          cap_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          bus_valid_q <= 1'b0;
          cap_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bus_out   = bus_out_q;
  assign bus.bus_sel   = bus_sel_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.cap_ready = cap_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.op_err    = op_err_q;

`ifdef ALU_DRAIN_ZERO_FLAG_EN
  logic zero_q;

  // Zero flag of the captured result, updated only on an accepted capture.
  always_ff @(posedge clk) begin
    if (!clr) begin
      zero_q <= 1'b0;
    end else if (state_q == IDLE && bus.cap) begin
      if (bus.alu_op >= OP_FIRST_ILLEGAL) begin
        zero_q <= 1'b0;
      end else if (bus.alu_op == OP_MUL || bus.alu_op == OP_DIV) begin
        zero_q <= (bus.alu_c == '0);
      end else begin
        zero_q <= (bus.alu_c[DATA_W-1:0] == '0);
      end
    end
  end

  assign bus.zero = zero_q;
`else
  assign bus.zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_drain.sv
// Directed self-checking bench for alu_result_drain: add, multiply, divide,
// backpressure with an ignored capture, illegal opcode, reset mid-drain.
module tb_alu_result_drain;

  logic clk;
  logic clr;
  int   checks;
  int   errors;

  alu_result_drain_if #(.DATA_W(32)) bus_if ();

  alu_result_drain #(.DATA_W(32)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_DRAIN_ZERO_FLAG_EN
  localparam logic ZERO_ON = 1'b1;
`else
  localparam logic ZERO_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"},     64'(bus_if.bus_valid), 64'd0);
    check({tag, ".cap_ready"}, 64'(bus_if.cap_ready), 64'd1);
    check({tag, ".busy"},      64'(bus_if.busy),      64'd0);
    check({tag, ".done"},      64'(bus_if.done),      64'd0);
  endtask

  task automatic check_beat(input string tag, input logic [31:0] data, input logic [1:0] sel);
    check({tag, ".valid"},     64'(bus_if.bus_valid), 64'd1);
    check({tag, ".out"},       64'(bus_if.bus_out),   64'(data));
    check({tag, ".sel"},       64'(bus_if.bus_sel),   64'(sel));
    check({tag, ".cap_ready"}, 64'(bus_if.cap_ready), 64'd0);
    check({tag, ".busy"},      64'(bus_if.busy),      64'd1);
    check({tag, ".done"},      64'(bus_if.done),      64'd0);
  endtask

  task automatic check_fin(input string tag);
    check({tag, ".done"},  64'(bus_if.done),      64'd1);
    check({tag, ".valid"}, 64'(bus_if.bus_valid), 64'd0);
  endtask

  task automatic capture(input logic [4:0] op, input logic [63:0] c);
    bus_if.alu_op = op;
    bus_if.alu_c  = c;
    bus_if.cap    = 1'b1;
    tick();
    bus_if.cap    = 1'b0;
    bus_if.alu_c  = 64'hDEAD_BEEF_DEAD_BEEF;
    bus_if.alu_op = 5'b00001;
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    clr              = 1'b0;
    bus_if.cap       = 1'b0;
    bus_if.bus_ready = 1'b1;
    bus_if.alu_c     = '0;
    bus_if.alu_op    = '0;
    tick();
    tick();

    // Reset values.
    check("rst.out",    64'(bus_if.bus_out), 64'd0);
    check("rst.sel",    64'(bus_if.bus_sel), 64'd0);
    check("rst.op_err", 64'(bus_if.op_err),  64'd0);
    check("rst.zero",   64'(bus_if.zero),    64'd0);
    check_idle("rst");
    clr = 1'b1;
    tick();

    // Add: single beat, done two cycles after capture.
    capture(5'b00011, 64'h0000_0000_0000_0007);
    check_beat("add.b1", 32'h0000_0007, 2'b00);
    check("add.zero", 64'(bus_if.zero), 64'd0);
    tick();
    check_fin("add.fin");
    tick();
    check_idle("add.idle");

    // Multiply: LO = C[31:0], HI = C[63:32].
    capture(5'b10000, 64'h0000_0001_8000_0000);
    check_beat("mul.b1", 32'h8000_0000, 2'b01);
    check("mul.zero", 64'(bus_if.zero), 64'd0);
    tick();
    check_beat("mul.b2", 32'h0000_0001, 2'b10);
    tick();
    check_fin("mul.fin");
    tick();
    check_idle("mul.idle");

    // Divide: LO = quotient C[63:32], HI = remainder C[31:0].
    capture(5'b01111, {32'd5, 32'd3});
    check_beat("div.b1", 32'd5, 2'b01);
    tick();
    check_beat("div.b2", 32'd3, 2'b10);
    tick();
    check_fin("div.fin");
    tick();
    check_idle("div.idle");

    // Multiply under backpressure, with a competing capture that must be ignored.
    bus_if.bus_ready = 1'b0;
    capture(5'b10000, 64'h0000_0001_8000_0000);
    bus_if.alu_op = 5'b01111;
    bus_if.alu_c  = 64'h1111_2222_3333_4444;
    bus_if.cap    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_beat("bp.hold", 32'h8000_0000, 2'b01);
      tick();
    end
    check_beat("bp.last", 32'h8000_0000, 2'b01);
    bus_if.cap       = 1'b0;
    bus_if.bus_ready = 1'b1;
    tick();
    check_beat("bp.b2", 32'h0000_0001, 2'b10);
    tick();
    check_fin("bp.fin");
    tick();
    check_idle("bp.idle");

    // Illegal opcode: op_err pulse, no beat, stays ready.
    capture(5'b10110, 64'h0000_0000_0000_00FF);
    check("ill.op_err", 64'(bus_if.op_err), 64'd1);
    check("ill.zero",   64'(bus_if.zero),   64'd0);
    check_idle("ill");
    tick();
    check("ill.op_err_clr", 64'(bus_if.op_err), 64'd0);
    check_idle("ill.after");

    // Reset while the HI beat is pending.
    bus_if.bus_ready = 1'b0;
    capture(5'b10000, 64'h0000_0001_8000_0000);
    bus_if.bus_ready = 1'b1;
    tick();
    bus_if.bus_ready = 1'b0;
    check_beat("rstm.b2", 32'h0000_0001, 2'b10);
    clr = 1'b0;
    tick();
    check("rstm.out",    64'(bus_if.bus_out), 64'd0);
    check("rstm.sel",    64'(bus_if.bus_sel), 64'd0);
    check("rstm.op_err", 64'(bus_if.op_err),  64'd0);
    check("rstm.zero",   64'(bus_if.zero),    64'd0);
    check_idle("rstm");
    clr              = 1'b1;
    bus_if.bus_ready = 1'b1;
    tick();
    check_idle("rstm.nodone");

    // Capture after reset drains normally; zero result flags zero when enabled.
    capture(5'b00011, 64'h0000_0000_0000_0000);
    check_beat("post.b1", 32'h0000_0000, 2'b00);
    check("post.zero", 64'(bus_if.zero), 64'(ZERO_ON));
    tick();
    check_fin("post.fin");
    tick();
    check_idle("post.idle");
    check("post.zero_hold", 64'(bus_if.zero), 64'(ZERO_ON));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
